// File: rtl/phy_tx_serializer.sv
// phy_tx_serializer: transmit half of the two-lane PHY.
// Takes 32-bit words over valid/ready, byte-stripes each word across two serial
// lanes (lane 0: byte3 then byte1, lane 1: byte2 then byte0, MSB first) and
// emits one bit per lane per clock. Every 16-cycle slot carries either one data
// word or the idle/sync byte on both lanes. After reset, SYNC_SLOTS idle slots
// go out before the word buffer is opened to the source.
module phy_tx_serializer #(
   parameter int unsigned SYNC_SLOTS = 4,
   parameter logic [7:0]  IDLE_BYTE  = 8'hBC
) (
   input  logic        clk_32f,
   input  logic        reset,
   input  logic [31:0] data_in,
   input  logic        valid_in,
   output logic        ready_out,
   output logic        data_out_0,
   output logic        data_out_1,
   output logic        active_out
);

   localparam int unsigned   SW        = $clog2(SYNC_SLOTS + 1);
   localparam logic [SW-1:0] SYNC_DONE = SW'(SYNC_SLOTS);
   localparam logic [15:0]   IDLE_SLOT = {IDLE_BYTE, IDLE_BYTE};

   logic [3:0]    bit_cnt_q,   bit_cnt_d;
   logic [SW-1:0] sync_cnt_q,  sync_cnt_d;
   logic [31:0]   word_q,      word_d;
   logic          word_full_q, word_full_d;
   logic [15:0]   shift_0_q,   shift_0_d;
   logic [15:0]   shift_1_q,   shift_1_d;
   logic          active_q,    active_d;

   logic          accept;
   logic          boundary;
   logic          sync_done;

   // Buffer is open only once the sync preamble is complete and it is empty.
   assign sync_done = (sync_cnt_q == SYNC_DONE);
   assign ready_out = sync_done && !word_full_q;
   assign accept    = valid_in && ready_out;
   assign boundary  = (bit_cnt_q == 4'd15);

   // Lanes and the slot flag come straight from registers: no input-to-output path.
   assign data_out_0 = shift_0_q[15];
   assign data_out_1 = shift_1_q[15];
   assign active_out = active_q;

   // Next-state: bit counter, slot loading at the boundary, word buffer fill.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      bit_cnt_d   = bit_cnt_q + 4'd1;
      sync_cnt_d  = sync_cnt_q;
      word_d      = word_q;
      word_full_d = word_full_q;
      shift_0_d   = shift_0_q;
      shift_1_d   = shift_1_q;
      active_d    = active_q;

      if (!boundary) begin
         shift_0_d = {shift_0_q[14:0], 1'b0};
         shift_1_d = {shift_1_q[14:0], 1'b0};
      end else begin
         if (!sync_done) begin
            sync_cnt_d = sync_cnt_q + SW'(1);
         end
         if (sync_done && word_full_q) begin
            shift_0_d   = {word_q[31:24], word_q[15:8]};
            shift_1_d   = {word_q[23:16], word_q[7:0]};
            word_full_d = 1'b0;
            active_d    = 1'b1;
         end else begin
            // Underflow or still syncing: fill the slot with the idle byte.
            shift_0_d = IDLE_SLOT;
            shift_1_d = IDLE_SLOT;
            active_d  = 1'b0;
         end
      end

      // ready_out is low whenever the buffer is full, so an accept never
      // collides with the boundary draining the buffer.
      if (accept) begin
         word_d      = data_in;
         word_full_d = 1'b1;
      end
   end

   // Control and shift state, cleared asynchronously to an idle slot 0.
   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         bit_cnt_q   <= 4'd0;
         sync_cnt_q  <= '0;
         word_full_q <= 1'b0;
         shift_0_q   <= IDLE_SLOT;
         shift_1_q   <= IDLE_SLOT;
         active_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         bit_cnt_q   <= bit_cnt_d;
         sync_cnt_q  <= sync_cnt_d;
         word_full_q <= word_full_d;
         shift_0_q   <= shift_0_d;
         shift_1_q   <= shift_1_d;
         active_q    <= active_d;
      end
   end

   // Word buffer payload.
   always_ff @(posedge clk_32f) begin
      // NOTE: the payload is not reset; word_full_q qualifies it, so a stale
      // value after reset is never launched.
      word_q <= word_d;
   end

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Self-checking bench for phy_tx_serializer. A slot-level reference model
// (queue of accepted words, slot index arithmetic) predicts every output on
// every cycle; scenario tasks add explicit checks for the key behaviours.
module tb_phy_tx_serializer;

   localparam int         SYNC_SLOTS = 4;
   localparam logic [7:0] IDLE_BYTE  = 8'hBC;

   logic        clk_32f  = 1'b0;
   logic        reset    = 1'b1;
   logic [31:0] data_in  = '0;
   logic        valid_in = 1'b0;
   logic        ready_out;
   logic        data_out_0;
   logic        data_out_1;
   logic        active_out;

   int checks = 0;
   int errors = 0;

   // Reference model state. m_cycle is the index of the cycle currently being
   // observed (cycle 0 precedes the first rising edge after reset release).
   int          m_cycle;
   logic [31:0] m_q[$];
   logic [31:0] m_slot_word;
   logic        m_slot_data;
   logic        last_acc;

   phy_tx_serializer #(
      .SYNC_SLOTS (SYNC_SLOTS),
      .IDLE_BYTE  (IDLE_BYTE)
   ) dut (
      .clk_32f    (clk_32f),
      .reset      (reset),
      .data_in    (data_in),
      .valid_in   (valid_in),
      .ready_out  (ready_out),
      .data_out_0 (data_out_0),
      .data_out_1 (data_out_1),
      .active_out (active_out)
   );

   always #5 clk_32f = ~clk_32f;

   // Idle lane bit for a position within the slot.
   function automatic logic idle_bit(input int c);
      logic [7:0] b;
      b = IDLE_BYTE;
      return b[7 - (c % 8)];
   endfunction

   // Expected {ready_out, active_out, data_out_1, data_out_0} for the current cycle.
   function automatic logic [3:0] model_out();
      int   p;
      logic l0, l1, rdy;
      p = m_cycle % 16;
      if (m_slot_data) begin
         l0 = (p < 8) ? m_slot_word[31 - p] : m_slot_word[15 - (p - 8)];
         l1 = (p < 8) ? m_slot_word[23 - p] : m_slot_word[7 - (p - 8)];
      end else begin
         l0 = idle_bit(m_cycle);
         l1 = l0;
      end
      rdy = ((m_cycle / 16) >= SYNC_SLOTS) && (m_q.size() == 0);
      return {rdy, m_slot_data, l1, l0};
   endfunction

   // Advance one clock and update the model with the inputs seen at that edge.
   task automatic tick();
      logic [3:0] e;
      e = model_out();
      @(posedge clk_32f);
      last_acc = valid_in && e[3];
      if ((m_cycle % 16) == 15) begin
         if ((m_cycle / 16) >= SYNC_SLOTS && m_q.size() > 0) begin
            m_slot_word = m_q.pop_front();
            m_slot_data = 1'b1;
         end else begin
            m_slot_data = 1'b0;
         end
      end
      if (last_acc) m_q.push_back(data_in);
      m_cycle++;
      #1;
   endtask

   // Hold reset for two edges, clear the model, release between edges.
   task automatic do_reset(input logic v, input logic [31:0] w);
      reset    = 1'b0;
      valid_in = 1'b0;
      repeat (2) @(posedge clk_32f);
      m_q.delete();
      m_slot_data = 1'b0;
      m_cycle     = 0;
      last_acc    = 1'b0;
      valid_in    = v;
      data_in     = w;
      @(negedge clk_32f);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      logic [3:0] obs, exp;
      #2 reset = 1'b0;
      #1;
      obs = {ready_out, active_out, data_out_1, data_out_0};
      checks++;
      if (obs !== 4'b0011) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=0011", obs);
      end
      do_reset(1'b0, 32'h0);
      for (int c = 0; c < 200; c++) begin
         obs = {ready_out, active_out, data_out_1, data_out_0};
         exp = model_out();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL reset_idle c=%0d got=%b exp=%b", m_cycle, obs, exp);
         end
         checks++;
         if (data_out_0 !== idle_bit(c) || data_out_1 !== idle_bit(c) || active_out !== 1'b0
             || ready_out !== (c >= 64)) begin
            errors++;
            $display("FAIL idle_pattern c=%0d got l0=%b l1=%b act=%b rdy=%b", c, data_out_0,
                     data_out_1, active_out, ready_out);
         end
         tick();
      end
   endtask

   task automatic test_single_word();
      logic [3:0]  obs, exp;
      logic [15:0] lane0, lane1;
      do_reset(1'b0, 32'h0);
      lane0 = '0;
      lane1 = '0;
      for (int c = 0; c < 100; c++) begin
         obs = {ready_out, active_out, data_out_1, data_out_0};
         exp = model_out();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL single_word c=%0d got=%b exp=%b", c, obs, exp);
         end
         if (c == 65) begin
            checks++;
            if (ready_out !== 1'b0) begin
               errors++;
               $display("FAIL single_ready_after_accept got=%b exp=0", ready_out);
            end
         end
         if (c >= 80 && c <= 95) begin
            lane0 = {lane0[14:0], data_out_0};
            lane1 = {lane1[14:0], data_out_1};
            checks++;
            if (active_out !== 1'b1) begin
               errors++;
               $display("FAIL single_active c=%0d got=%b exp=1", c, active_out);
            end
         end
         if (c == 96) begin
            checks++;
            if (active_out !== 1'b0 || data_out_0 !== 1'b1 || data_out_1 !== 1'b1) begin
               errors++;
               $display("FAIL single_idle_resume got act=%b l0=%b l1=%b exp 0 1 1",
                        active_out, data_out_0, data_out_1);
            end
         end
         valid_in = (c == 64);
         data_in  = (c == 64) ? 32'hA1B2C3D4 : 32'h0;
         tick();
      end
      valid_in = 1'b0;
      checks++;
      if (lane0 !== 16'hA1C3 || lane1 !== 16'hB2D4) begin
         errors++;
         $display("FAIL single_lanes got l0=%h l1=%h exp l0=a1c3 l1=b2d4", lane0, lane1);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  obs, exp;
      logic [31:0] words [3];
      int          idx, rdy_cnt, act_cnt, run, max_run, start;
      words[0] = 32'h1;
      words[1] = 32'h2;
      words[2] = 32'h3;
      do_reset(1'b0, 32'h0);
      start = 64 + $urandom_range(0, 20);
      idx = 0; rdy_cnt = 0; act_cnt = 0; run = 0; max_run = 0;
      for (int c = 0; c < start + 120; c++) begin
         obs = {ready_out, active_out, data_out_1, data_out_0};
         exp = model_out();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL back_to_back c=%0d got=%b exp=%b", c, obs, exp);
         end
         if (c == start) begin
            valid_in = 1'b1;
            data_in  = words[0];
         end
         if (valid_in && ready_out) rdy_cnt++;
         if (active_out) begin
            act_cnt++;
            run++;
            if (run > max_run) max_run = run;
         end else begin
            run = 0;
         end
         tick();
         if (last_acc) begin
            idx++;
            if (idx < 3) data_in = words[idx];
            else valid_in = 1'b0;
         end
      end
      valid_in = 1'b0;
      checks++;
      if (rdy_cnt !== 3 || act_cnt !== 48 || max_run !== 48) begin
         errors++;
         $display("FAIL back_to_back_summary got rdy=%0d act=%0d run=%0d exp 3 48 48",
                  rdy_cnt, act_cnt, max_run);
      end
   endtask

   task automatic test_idle_byte_word();
      logic [3:0] obs, exp;
      int         act_cnt, mism;
      act_cnt = 0; mism = 0;
      valid_in = 1'b1;
      data_in  = 32'hBCBCBCBC;
      for (int c = 0; c < 70; c++) begin
         obs = {ready_out, active_out, data_out_1, data_out_0};
         exp = model_out();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL idle_byte_word c=%0d got=%b exp=%b", m_cycle, obs, exp);
         end
         if (active_out) begin
            act_cnt++;
            if (data_out_0 !== idle_bit(m_cycle) || data_out_1 !== idle_bit(m_cycle)) mism++;
         end
         tick();
         if (last_acc) valid_in = 1'b0;
      end
      valid_in = 1'b0;
      checks++;
      if (act_cnt !== 16 || mism !== 0) begin
         errors++;
         $display("FAIL idle_byte_word_slot got act=%0d mism=%0d exp 16 0", act_cnt, mism);
      end
   endtask

   task automatic test_sync_hold();
      logic [3:0]  obs, exp;
      logic [31:0] w;
      logic [15:0] lane0, lane1;
      w = $urandom;
      lane0 = '0;
      lane1 = '0;
      do_reset(1'b1, w);
      for (int c = 0; c < 100; c++) begin
         obs = {ready_out, active_out, data_out_1, data_out_0};
         exp = model_out();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL sync_hold c=%0d got=%b exp=%b", c, obs, exp);
         end
         if (c == 63 || c == 64 || c == 65) begin
            checks++;
            if (ready_out !== (c == 64)) begin
               errors++;
               $display("FAIL sync_hold_ready c=%0d got=%b exp=%b", c, ready_out, c == 64);
            end
         end
         if (c >= 80 && c <= 95) begin
            lane0 = {lane0[14:0], data_out_0};
            lane1 = {lane1[14:0], data_out_1};
         end
         tick();
         if (last_acc) valid_in = 1'b0;
      end
      valid_in = 1'b0;
      checks++;
      if (lane0 !== {w[31:24], w[15:8]} || lane1 !== {w[23:16], w[7:0]}) begin
         errors++;
         $display("FAIL sync_hold_lanes got l0=%h l1=%h exp l0=%h l1=%h", lane0, lane1,
                  {w[31:24], w[15:8]}, {w[23:16], w[7:0]});
      end
   endtask

   task automatic test_random();
      logic [3:0] obs, exp;
      valid_in = $urandom_range(0, 1);
      data_in  = $urandom;
      for (int c = 0; c < 600; c++) begin
         obs = {ready_out, active_out, data_out_1, data_out_0};
         exp = model_out();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL random c=%0d got=%b exp=%b", m_cycle, obs, exp);
         end
         tick();
         // Hold a presented word until it is taken; otherwise re-roll.
         if (last_acc || !valid_in) begin
            valid_in = ($urandom_range(0, 3) != 0);
            data_in  = $urandom;
         end
      end
      valid_in = 1'b0;
   endtask

   task automatic test_reset_mid_slot();
      logic [3:0] obs, exp;
      logic       found;
      int         act_cnt;
      do_reset(1'b1, $urandom);
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         obs = {ready_out, active_out, data_out_1, data_out_0};
         exp = model_out();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL mid_reset_setup c=%0d got=%b exp=%b", m_cycle, obs, exp);
         end
         if (m_slot_data && (m_cycle % 16) == 7 && m_q.size() == 1) begin
            found = 1'b1;
         end else begin
            tick();
            if (last_acc) data_in = $urandom;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL mid_reset_reach got=timeout exp=data slot with full buffer");
      end
      reset = 1'b0;
      #1;
      obs = {ready_out, active_out, data_out_1, data_out_0};
      checks++;
      if (obs !== 4'b0011) begin
         errors++;
         $display("FAIL mid_reset_async got=%b exp=0011", obs);
      end
      @(posedge clk_32f);
      #1;
      obs = {ready_out, active_out, data_out_1, data_out_0};
      checks++;
      if (obs !== 4'b0011) begin
         errors++;
         $display("FAIL mid_reset_held got=%b exp=0011", obs);
      end
      do_reset(1'b0, 32'h0);
      act_cnt = 0;
      for (int c = 0; c < 160; c++) begin
         obs = {ready_out, active_out, data_out_1, data_out_0};
         exp = model_out();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL mid_reset_after c=%0d got=%b exp=%b", c, obs, exp);
         end
         if (active_out) act_cnt++;
         tick();
      end
      checks++;
      if (act_cnt !== 0) begin
         errors++;
         $display("FAIL mid_reset_dropped got act_cycles=%0d exp=0", act_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_idle_byte_word();
      test_sync_hold();
      test_random();
      test_reset_mid_slot();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
